// File: rtl/flash_ctrl.sv
// Bus-cycle sequencer for an 8-bit parallel NOR flash: timed CE/OE/WE read and write cycles plus the reset pulse.
// Optional macro FLASH_CTRL_STS_WAIT_EN adds a post-write wait on the flash ready pin (NF_STS) with timeout.
module flash_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 3,
    parameter int T_HOLD      = 1,
    parameter int T_RP        = 4,
    parameter int STS_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              err,
    output logic [ADDR_W-1:0] NF_A,
    inout  wire  [7:0]        NF_D,
    output logic              NF_CE,
    output logic              NF_OE,
    output logic              NF_WE,
    output logic              NF_RP,
    output logic              NF_WP,
    output logic              NF_BYTE,
    input  logic              NF_STS,
    output logic [2:0]        o_dbg_state
);
    // Handshake: req is accepted on a rising edge only while busy=0; done pulses
    // for one cycle when the accepted operation finishes, and busy falls in that same cycle.

    localparam int CNT_W = $clog2(T_SETUP + T_PULSE + T_HOLD + T_RP + STS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_RP_HOLD,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
`ifdef FLASH_CTRL_STS_WAIT_EN
        ,
        S_STS_WAIT
`endif
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic             r_d_oe;
    logic [7:0]       r_dout;
    logic [7:0]       r_cap;
    logic             r_sts_s2;

    assign NF_WP       = 1'b1;
    assign NF_BYTE     = 1'b0;
    assign NF_D        = r_d_oe ? r_dout : 8'hzz;
    assign o_dbg_state = r_state;

`ifdef FLASH_CTRL_STS_WAIT_EN
    logic r_sts_s1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sts_s1 <= 1'b0;
            r_sts_s2 <= 1'b0;
        end else begin
            r_sts_s1 <= NF_STS;
            r_sts_s2 <= r_sts_s1;
        end
    end
`else
    logic w_unused_sts;
    assign w_unused_sts = NF_STS;
    assign r_sts_s2     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RP_HOLD;
            r_cnt   <= CNT_W'(T_RP - 1);
            r_we    <= 1'b0;
            r_d_oe  <= 1'b0;
            r_dout  <= 8'h00;
            r_cap   <= 8'h00;
            busy    <= 1'b1;
            done    <= 1'b0;
            rdata   <= 8'h00;
            err     <= 1'b0;
            NF_A    <= '0;
            NF_CE   <= 1'b1;
            NF_OE   <= 1'b1;
            NF_WE   <= 1'b1;
            NF_RP   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_RP_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        NF_RP   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        r_state <= S_SETUP;
                        r_cnt   <= CNT_W'(T_SETUP - 1);
                        r_we    <= we;
                        r_dout  <= wdata;
                        r_d_oe  <= we;
                        NF_A    <= addr;
                        NF_CE   <= 1'b0;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_PULSE;
                        r_cnt   <= CNT_W'(T_PULSE - 1);
                        NF_OE   <= r_we;
                        NF_WE   <= ~r_we;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        r_cnt   <= CNT_W'(T_HOLD - 1);
                        NF_OE   <= 1'b1;
                        NF_WE   <= 1'b1;
                        // Sample while OE is still low; rdata itself only changes at done.
                        if (!r_we) r_cap <= NF_D;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        NF_CE  <= 1'b1;
                        r_d_oe <= 1'b0;
`ifdef FLASH_CTRL_STS_WAIT_EN
                        if (r_we) begin
                            r_state <= S_STS_WAIT;
                            r_cnt   <= CNT_W'(STS_TIMEOUT - 1);
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rdata   <= r_cap;
                        end
`else
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (!r_we) rdata <= r_cap;
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
`ifdef FLASH_CTRL_STS_WAIT_EN
                S_STS_WAIT: begin
                    if (r_sts_s2 || r_cnt == '0) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= ~r_sts_s2;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
`endif
                default: begin
                    r_state <= S_RP_HOLD;
                    r_cnt   <= CNT_W'(T_RP - 1);
                    busy    <= 1'b1;
                    NF_RP   <= 1'b0;
                    NF_CE   <= 1'b1;
                    NF_OE   <= 1'b1;
                    NF_WE   <= 1'b1;
                    r_d_oe  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: flash memory model, cycle-timeline reference model and directed vectors.
module tb_flash_ctrl;
  localparam int T_SETUP = 2;
  localparam int T_PULSE = 3;
  localparam int T_HOLD  = 1;
  localparam int T_RP    = 4;
  localparam int STS_TO  = 16;
  localparam int TOT     = T_SETUP + T_PULSE + T_HOLD;
`ifdef FLASH_CTRL_STS_WAIT_EN
  localparam int STS_X = 1;
`else
  localparam int STS_X = 0;
`endif
  localparam int W_DONE = TOT + 1 + STS_X;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req, we, nf_sts;
  logic [7:0] addr, wdata, rdata, nf_a;
  logic busy, done, err, nf_ce, nf_oe, nf_we, nf_rp, nf_wp, nf_byte;
  logic [2:0] unused_dbg_state;
  wire  [7:0] nf_d;

  int n_checks = 0;
  int n_errors = 0;
  logic cmp_on = 1'b0;

  flash_ctrl #(.ADDR_W(8), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
               .T_RP(T_RP), .STS_TIMEOUT(STS_TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .NF_A(nf_a), .NF_D(nf_d), .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we),
    .NF_RP(nf_rp), .NF_WP(nf_wp), .NF_BYTE(nf_byte), .NF_STS(nf_sts),
    .o_dbg_state(unused_dbg_state)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h33;
  endfunction

  // flash device: drives the bus while CE and OE are low, latches on WE rising with CE low
  bit         f_wr  [0:255];
  logic [7:0] f_mem [0:255];
  wire  [7:0] f_q = f_wr[nf_a] ? f_mem[nf_a] : init_val(nf_a);
  assign nf_d = (!nf_ce && !nf_oe) ? f_q : 8'hzz;
  pullup (nf_d);
  always @(posedge nf_we) begin
    if (!nf_ce) begin
      f_mem[nf_a] <= nf_d;
      f_wr[nf_a]  <= 1'b1;
    end
  end

  // reference model: position of each cycle within the operation timeline
  int         m_rp, m_k, m_last;
  logic       m_done, m_we;
  logic [7:0] m_addr, m_wdata, m_rdata, m_a_last;
  bit         m_wr  [0:255];
  logic [7:0] m_mem [0:255];

  function automatic logic [7:0] m_val(input logic [7:0] a);
    return m_wr[a] ? m_mem[a] : init_val(a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rp <= T_RP; m_k <= 0; m_done <= 1'b0; m_rdata <= 8'h00; m_a_last <= 8'h00;
    end else begin
      m_done <= 1'b0;
      if (m_rp > 0) begin
        m_rp <= m_rp - 1;
      end else if (m_k > 0) begin
        if (m_k == m_last) begin
          m_k    <= 0;
          m_done <= 1'b1;
          if (m_we) begin
            m_mem[m_addr] <= m_wdata;
            m_wr[m_addr]  <= 1'b1;
          end else begin
            m_rdata <= m_val(m_addr);
          end
        end else begin
          m_k <= m_k + 1;
        end
      end else if (req) begin
        m_k <= 1; m_we <= we; m_addr <= addr; m_wdata <= wdata; m_a_last <= addr;
        m_last <= we ? TOT + STS_X : TOT;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process
  logic       e_win, e_str;
  logic [7:0] e_d;
  always @(negedge clk) begin
    if (cmp_on) begin
      e_win = (m_k >= 1) && (m_k <= TOT);
      e_str = (m_k >= T_SETUP + 1) && (m_k <= T_SETUP + T_PULSE);
      e_d   = (e_win && m_we) ? m_wdata : ((e_str && !m_we) ? m_val(m_addr) : 8'hFF);
      chk("busy",    32'(busy),    32'((m_rp > 0) || (m_k > 0)));
      chk("done",    32'(done),    32'(m_done));
      chk("nf_rp",   32'(nf_rp),   32'(m_rp == 0));
      chk("nf_ce",   32'(nf_ce),   32'(!e_win));
      chk("nf_oe",   32'(nf_oe),   32'(!(e_str && !m_we)));
      chk("nf_we",   32'(nf_we),   32'(!(e_str && m_we)));
      chk("nf_a",    32'(nf_a),    32'(m_a_last));
      chk("nf_d",    32'(nf_d),    32'(e_d));
      chk("rdata",   32'(rdata),   32'(m_rdata));
      chk("err",     32'(err),     32'd0);
      chk("nf_wp",   32'(nf_wp),   32'd1);
      chk("nf_byte", 32'(nf_byte), 32'd0);
    end
  end

  // driver: one request, then observe until done (bounded)
  task automatic run_op(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int extra_at, input int sts_at,
                        output int t_done, output int n_ce, output int n_wl,
                        output int n_ol, output int n_drv);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    t_done = -1; n_ce = 0; n_wl = 0; n_ol = 0; n_drv = 0;
    for (int k = 1; k <= 60 && t_done < 0; k++) begin
      if (k == extra_at) begin req = 1'b1; we = 1'b0; addr = a ^ 8'hFF; end
      if (k == sts_at) nf_sts = 1'b1;
      @(negedge clk);
      if (!nf_ce) n_ce++;
      if (!nf_we) n_wl++;
      if (!nf_oe) n_ol++;
      if (w && !nf_ce && nf_d == d) n_drv++;
      if (done) t_done = k;
      @(posedge clk); #1;
      req = 1'b0;
    end
    if (t_done < 0) chk("op_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rp(output int n_low, output int n_done);
    n_low = 0; n_done = 0;
    for (int k = 0; k < 12 && nf_rp == 1'b0; k++) begin
      @(negedge clk);
      if (!nf_rp) n_low++;
      if (done) n_done++;
    end
  endtask

  logic [7:0] tv_addr [5] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h81};
  logic [7:0] tv_data [5] = '{8'h5A, 8'h0F, 8'h00, 8'h00, 8'h00};
  logic       tv_we   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] tv_exp  [5] = '{8'h00, 8'h00, 8'h5A, 8'h0F, 8'hB2};

  initial begin
    int t_done, n_ce, n_wl, n_ol, n_drv, n_low, n_done;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00; nf_sts = 1'b1;
    repeat (3) @(posedge clk);
    cmp_on = 1'b1;
    #1 rst = 1'b0;
    wait_rp(n_low, n_done);
    chk("reset_rp_low_cycles", 32'(n_low), 32'd4);

    run_op(1'b1, 8'h3C, 8'hA5, 0, 0, t_done, n_ce, n_wl, n_ol, n_drv);
    chk("wr_done_cycle", 32'(t_done), 32'(W_DONE));
    chk("wr_ce_low",     32'(n_ce),   32'd6);
    chk("wr_we_low",     32'(n_wl),   32'd3);
    chk("wr_oe_low",     32'(n_ol),   32'd0);
    chk("wr_d_driven",   32'(n_drv),  32'd6);
    chk("flash_holds",   32'(f_mem[8'h3C]), 32'hA5);

    run_op(1'b0, 8'h3C, 8'h00, 0, 0, t_done, n_ce, n_wl, n_ol, n_drv);
    chk("rd_done_cycle", 32'(t_done), 32'd7);
    chk("rd_oe_low",     32'(n_ol),   32'd3);
    chk("rd_we_low",     32'(n_wl),   32'd0);
    chk("rd_rdata",      32'(rdata),  32'hA5);

    run_op(1'b0, 8'h10, 8'h00, 3, 0, t_done, n_ce, n_wl, n_ol, n_drv);
    chk("ign_done_cycle", 32'(t_done), 32'd7);
    chk("ign_ce_low",     32'(n_ce),   32'd6);
    chk("ign_rdata",      32'(rdata),  32'h23);
    n_ce = 0; n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (!nf_ce) n_ce++;
      if (done) n_done++;
    end
    chk("ign_no_second_ce",   32'(n_ce),   32'd0);
    chk("ign_no_second_done", 32'(n_done), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(tv_we[i], tv_addr[i], tv_data[i], 0, 0, t_done, n_ce, n_wl, n_ol, n_drv);
      chk("tv_done_cycle", 32'(t_done), tv_we[i] ? 32'(W_DONE) : 32'd7);
      if (!tv_we[i]) chk("tv_rdata", 32'(rdata), 32'(tv_exp[i]));
    end

    // reset in the middle of a write strobe
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 8'h77; wdata = 8'h11;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_we_low", 32'(nf_we), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_we_high", 32'(nf_we), 32'd1);
    chk("mid_ce_high", 32'(nf_ce), 32'd1);
    chk("mid_d_rel",   32'(nf_d),  32'hFF);
    chk("mid_rp_low",  32'(nf_rp), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_rp(n_low, n_done);
    chk("mid_rp_low_cycles", 32'(n_low),  32'd4);
    chk("mid_no_done",       32'(n_done), 32'd0);
    run_op(1'b0, 8'h3C, 8'h00, 0, 0, t_done, n_ce, n_wl, n_ol, n_drv);
    chk("post_rst_rd_cycle", 32'(t_done), 32'd7);
    chk("post_rst_rdata",    32'(rdata),  32'hA5);

`ifdef FLASH_CTRL_STS_WAIT_EN
    @(negedge clk);
    cmp_on = 1'b0;
    nf_sts = 1'b0;
    run_op(1'b1, 8'h20, 8'h44, 0, 0, t_done, n_ce, n_wl, n_ol, n_drv);
    chk("sts_timeout_cycle", 32'(t_done), 32'(7 + STS_TO));
    chk("sts_timeout_err",   32'(err),    32'd1);
    nf_sts = 1'b0;
    run_op(1'b1, 8'h21, 8'h45, 0, 12, t_done, n_ce, n_wl, n_ol, n_drv);
    chk("sts_ready_within3", 32'((t_done >= 13) && (t_done <= 15)), 32'd1);
    chk("sts_ready_err",     32'(err), 32'd0);
`endif

    @(negedge clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
